cfu_cmd_issuer: RTL and testbench
=================================

// Module: cfu_cmd_issuer
// PURPOSE
//  Initiator side of the CFU command/response bus; counterpart of cfu_decode.
//  Accepts {op, subop, operands} from a local requester and packs
//  function_id = {subop[6:0], op[2:0]}. Drives one cmd transaction, waits for
//  rsp, then returns the result. Used as host-side driver and bus master for
//  accel_imgc benches. One transaction outstanding at a time.
// PARAMETERS
//  DATA_W          32    operand/result width
//  TIMEOUT_CYCLES  1024  max cycles in WAIT before abort; 0 disables timeout
//  STRAY_W         8     width of stray-response counter
// PORTS
//  clk                      in   1        clock, all logic on rising edge
//  reset_n                  in   1        asynchronous active-low reset
//  req_valid                in   1        requester command valid
//  req_ready                out  1        issuer can accept a request
//  req_op                   in   3        op field -> function_id[2:0]
//  req_subop                in   7        subop field -> function_id[9:3]
//  req_in0                  in   DATA_W   operand 0
//  req_in1                  in   DATA_W   operand 1
//  cmd_valid                out  1        CFU command valid
//  cmd_ready                in   1        CFU accepts command
//  cmd_payload_function_id  out  10       {subop, op}
//  cmd_payload_inputs_0     out  DATA_W   operand 0
//  cmd_payload_inputs_1     out  DATA_W   operand 1
//  rsp_valid                in   1        CFU response valid
//  rsp_ready                out  1        issuer accepts response
//  rsp_payload_outputs_0    in   DATA_W   CFU result
//  res_valid                out  1        result available to requester
//  res_ready                in   1        requester takes result
//  res_data                 out  DATA_W   result (0 on timeout)
//  res_timeout              out  1        result produced by timeout
//  stray_count              out  STRAY_W  saturating count of discarded rsps
// BEHAVIOUR
//  - Reset (reset_n=0, async): state=IDLE; cmd_valid, res_valid, res_timeout,
//    res_data, cmd payloads, stray_count, timer all 0. Abandons any
//    transaction in flight; nothing is replayed after reset release.
//  - FSM: IDLE -> SEND -> WAIT -> DONE -> IDLE.
//  - IDLE: req_ready=1. On req_valid, register payload, go to SEND.
//    cmd_valid rises on the next cycle (1-cycle latency).
//  - SEND: cmd_valid=1 with stable payload until cmd_ready.
//    Accept cycle: go to WAIT, clear timer. cmd_valid & cmd_ready is a transfer.
//  - WAIT: rsp_ready=1. On rsp_valid, capture outputs_0 into res_data,
//    set res_timeout=0, go to DONE. Otherwise timer++.
//    If TIMEOUT_CYCLES!=0 and timer==TIMEOUT_CYCLES-1 with no rsp:
//    res_data=0, res_timeout=1, go to DONE.
//    If rsp_valid arrives in the expiry cycle, the response wins.
//  - DONE: res_valid=1 and res_data/res_timeout are stable until res_ready,
//    then go to IDLE. req_ready=0 in DONE; no back-to-back bypass.
//  - Stray responses: rsp_ready=1 in IDLE, SEND and DONE too. An rsp_valid
//    accepted outside WAIT is discarded. stray_count++ saturates at all-ones.
//  - req_ready=1 only in IDLE; rsp_ready=0 never.
//  - Outputs are registered, except req_ready and rsp_ready, which decode
//    from state.
//  - Min round trip with cmd_ready=1, 1-cycle CFU, res_ready=1: 4 cycles
//    from req accept to res_valid falling.
// TESTING
//  1 Pack: op=3'b111, subop=7'b0000001, in0=5, in1=7
//    -> function_id=10'b0000001111, inputs match, cmd_valid 1 cycle after
//    req accept.
//  2 Backpressure: hold cmd_ready=0 for 5 cycles -> cmd_valid and payload
//    stable, req_ready=0 throughout. Single transfer when cmd_ready=1.
//  3 Response: rsp_valid with outputs_0=32'hDEADBEEF 3 cycles after cmd
//    -> res_valid next cycle, res_data=DEADBEEF, res_timeout=0.
//    Held until res_ready.
//  4 Timeout: TIMEOUT_CYCLES=8, no rsp -> res_valid after 8 WAIT cycles,
//    res_timeout=1, res_data=0. Late rsp in IDLE -> stray_count=1.
//    Repeat with rsp in expiry cycle -> res_timeout=0.
//  5 Reset mid-WAIT: drop reset_n -> cmd_valid=0 and res_valid=0 at once.
//    After release, req_ready=1. Next transaction completes normally.
//  6 Stress: 200 random op/subop/operands, random ready/valid delays
//    -> every function_id == {subop, op}, results in order, no drops or
//    duplicates.

Source files
------------

// File: rtl/cfu_cmd_issuer.sv
// Initiator side of the CFU command/response bus. Issues one command at a time,
// waits for the response (or times out) and hands the result back to the requester.
module cfu_cmd_issuer #(
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int STRAY_W        = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [2:0]          req_op,
    input  logic [6:0]          req_subop,
    input  logic [DATA_W-1:0]   req_in0,
    input  logic [DATA_W-1:0]   req_in1,
    output logic                cmd_valid,
    input  logic                cmd_ready,
    output logic [9:0]          cmd_payload_function_id,
    output logic [DATA_W-1:0]   cmd_payload_inputs_0,
    output logic [DATA_W-1:0]   cmd_payload_inputs_1,
    input  logic                rsp_valid,
    output logic                rsp_ready,
    input  logic [DATA_W-1:0]   rsp_payload_outputs_0,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [DATA_W-1:0]   res_data,
    output logic                res_timeout,
    output logic [STRAY_W-1:0]  stray_count
);

    localparam int TMR_W      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int TMR_LAST_I = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TMR_LAST_I);
    localparam bit TMR_EN = (TIMEOUT_CYCLES != 0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic                 cmd_valid_q, cmd_valid_d;
    logic [9:0]           fid_q, fid_d;
    logic [DATA_W-1:0]    in0_q, in0_d;
    logic [DATA_W-1:0]    in1_q, in1_d;
    logic                 res_valid_q, res_valid_d;
    logic [DATA_W-1:0]    res_data_q, res_data_d;
    logic                 res_timeout_q, res_timeout_d;
    logic [TMR_W-1:0]     timer_q, timer_d;
    logic [STRAY_W-1:0]   stray_q, stray_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            cmd_valid_q   <= 1'b0;
            fid_q         <= '0;
            in0_q         <= '0;
            in1_q         <= '0;
            res_valid_q   <= 1'b0;
            res_data_q    <= '0;
            res_timeout_q <= 1'b0;
            timer_q       <= '0;
            stray_q       <= '0;
        end else begin
            state_q       <= state_d;
            cmd_valid_q   <= cmd_valid_d;
            fid_q         <= fid_d;
            in0_q         <= in0_d;
            in1_q         <= in1_d;
            res_valid_q   <= res_valid_d;
            res_data_q    <= res_data_d;
            res_timeout_q <= res_timeout_d;
            timer_q       <= timer_d;
            stray_q       <= stray_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cmd_valid_d   = cmd_valid_q;
        fid_d         = fid_q;
        in0_d         = in0_q;
        in1_d         = in1_q;
        res_valid_d   = res_valid_q;
        res_data_d    = res_data_q;
        res_timeout_d = res_timeout_q;
        timer_d       = timer_q;
        stray_d       = stray_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    fid_d       = {req_subop, req_op};
                    in0_d       = req_in0;
                    in1_d       = req_in1;
                    cmd_valid_d = 1'b1;
                    state_d     = S_SEND;
                end
            end
            S_SEND: begin
                if (cmd_ready) begin
                    cmd_valid_d = 1'b0;
                    timer_d     = '0;
                    state_d     = S_WAIT;
                end
            end
            S_WAIT: begin
                // A response arriving in the expiry cycle takes priority over the timeout.
                if (rsp_valid) begin
                    res_data_d    = rsp_payload_outputs_0;
                    res_timeout_d = 1'b0;
                    res_valid_d   = 1'b1;
                    state_d       = S_DONE;
                end else if (TMR_EN && (timer_q == TMR_LAST)) begin
                    res_data_d    = '0;
                    res_timeout_d = 1'b1;
                    res_valid_d   = 1'b1;
                    state_d       = S_DONE;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            S_DONE: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Responses are always accepted; outside WAIT they belong to no transaction.
        if (rsp_valid && (state_q != S_WAIT) && (stray_q != {STRAY_W{1'b1}})) begin
            stray_d = stray_q + STRAY_W'(1);
        end
    end

    assign req_ready               = (state_q == S_IDLE);
    assign rsp_ready               = 1'b1;
    assign cmd_valid               = cmd_valid_q;
    assign cmd_payload_function_id = fid_q;
    assign cmd_payload_inputs_0    = in0_q;
    assign cmd_payload_inputs_1    = in1_q;
    assign res_valid               = res_valid_q;
    assign res_data                = res_data_q;
    assign res_timeout             = res_timeout_q;
    assign stray_count             = stray_q;

endmodule

// File: tb/tb_cfu_cmd_issuer.sv
// Bench for cfu_cmd_issuer: directed scenarios plus a randomized stress run
// against a queue-based model of the requester/CFU round trip.
module tb_cfu_cmd_issuer;

    localparam int DATA_W  = 32;
    localparam int TO      = 8;
    localparam int STRAY_W = 8;
    localparam int N_TXN   = 200;

    logic                clk = 1'b0;
    logic                reset_n = 1'b0;
    logic                req_valid = 1'b0;
    logic                req_ready;
    logic [2:0]          req_op = '0;
    logic [6:0]          req_subop = '0;
    logic [DATA_W-1:0]   req_in0 = '0;
    logic [DATA_W-1:0]   req_in1 = '0;
    logic                cmd_valid;
    logic                cmd_ready = 1'b0;
    logic [9:0]          cmd_payload_function_id;
    logic [DATA_W-1:0]   cmd_payload_inputs_0;
    logic [DATA_W-1:0]   cmd_payload_inputs_1;
    logic                rsp_valid = 1'b0;
    logic                rsp_ready;
    logic [DATA_W-1:0]   rsp_payload_outputs_0 = '0;
    logic                res_valid;
    logic                res_ready = 1'b0;
    logic [DATA_W-1:0]   res_data;
    logic                res_timeout;
    logic [STRAY_W-1:0]  stray_count;

    cfu_cmd_issuer #(
        .DATA_W(DATA_W), .TIMEOUT_CYCLES(TO), .STRAY_W(STRAY_W)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_subop(req_subop), .req_in0(req_in0), .req_in1(req_in1),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_payload_function_id(cmd_payload_function_id),
        .cmd_payload_inputs_0(cmd_payload_inputs_0),
        .cmd_payload_inputs_1(cmd_payload_inputs_1),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_payload_outputs_0(rsp_payload_outputs_0),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_timeout(res_timeout), .stray_count(stray_count)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [9:0]        fid;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } req_t;

    req_t              req_q[$];
    logic [DATA_W-1:0] res_q[$];
    int sent, served, got, stress_lim;

    // Behaviour of the stand-in CFU: any fixed function of the command works.
    function automatic logic [DATA_W-1:0] cfu_model(logic [9:0] fid, logic [DATA_W-1:0] a,
                                                    logic [DATA_W-1:0] b);
        return (a + b) ^ {22'd0, fid};
    endfunction

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        vectors++; if (cmd_valid !== 1'b0) begin miscompares++; $display("FAIL reset_cmd_valid got %b want 0", cmd_valid); end
        vectors++; if (res_valid !== 1'b0) begin miscompares++; $display("FAIL reset_res_valid got %b want 0", res_valid); end
        vectors++; if (res_timeout !== 1'b0) begin miscompares++; $display("FAIL reset_res_timeout got %b want 0", res_timeout); end
        vectors++; if (res_data !== '0) begin miscompares++; $display("FAIL reset_res_data got %h want 0", res_data); end
        vectors++; if (stray_count !== '0) begin miscompares++; $display("FAIL reset_stray got %0d want 0", stray_count); end
        vectors++; if ({cmd_payload_function_id, cmd_payload_inputs_0, cmd_payload_inputs_1} !== '0) begin
            miscompares++; $display("FAIL reset_payload got %h/%h/%h want 0", cmd_payload_function_id, cmd_payload_inputs_0, cmd_payload_inputs_1); end
        vectors++; if (req_ready !== 1'b1 || rsp_ready !== 1'b1) begin miscompares++; $display("FAIL reset_readies got req %b rsp %b want 1 1", req_ready, rsp_ready); end
        reset_n = 1'b1;
        @(negedge clk);
        vectors++; if (req_ready !== 1'b1 || cmd_valid !== 1'b0) begin miscompares++; $display("FAIL post_reset got req_ready %b cmd_valid %b want 1 0", req_ready, cmd_valid); end
    endtask

    task automatic test_pack();
        req_valid = 1'b1; req_op = 3'b111; req_subop = 7'b0000001; req_in0 = 5; req_in1 = 7; cmd_ready = 1'b0;
        vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL pack_req_ready got %b want 1", req_ready); end
        @(negedge clk);
        req_valid = 1'b0; req_op = '0; req_subop = '0; req_in0 = 32'hFFFF_FFFF; req_in1 = 32'hFFFF_FFFF;
        vectors++; if (cmd_valid !== 1'b1) begin miscompares++; $display("FAIL pack_cmd_valid got %b want 1", cmd_valid); end
        vectors++; if (cmd_payload_function_id !== 10'b0000001111) begin miscompares++; $display("FAIL pack_fid got %b want 0000001111", cmd_payload_function_id); end
        vectors++; if (cmd_payload_inputs_0 !== 32'd5 || cmd_payload_inputs_1 !== 32'd7) begin
            miscompares++; $display("FAIL pack_inputs got %0d %0d want 5 7", cmd_payload_inputs_0, cmd_payload_inputs_1); end
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 5; i++) begin
            vectors++; if (cmd_valid !== 1'b1 || req_ready !== 1'b0 || cmd_payload_function_id !== 10'b0000001111 ||
                           cmd_payload_inputs_0 !== 32'd5 || cmd_payload_inputs_1 !== 32'd7) begin
                miscompares++; $display("FAIL bp_hold[%0d] got v%b rr%b fid %b in %0d %0d want v1 rr0 0000001111 5 7",
                                        i, cmd_valid, req_ready, cmd_payload_function_id, cmd_payload_inputs_0, cmd_payload_inputs_1); end
            @(negedge clk);
        end
        cmd_ready = 1'b1;
        @(negedge clk);
        cmd_ready = 1'b0;
        vectors++; if (cmd_valid !== 1'b0 || req_ready !== 1'b0) begin miscompares++; $display("FAIL bp_single_xfer got cmd_valid %b req_ready %b want 0 0", cmd_valid, req_ready); end
    endtask

    task automatic test_response();
        for (int i = 0; i < 2; i++) begin
            vectors++; if (res_valid !== 1'b0) begin miscompares++; $display("FAIL rsp_early_res[%0d] got %b want 0", i, res_valid); end
            @(negedge clk);
        end
        rsp_valid = 1'b1; rsp_payload_outputs_0 = 32'hDEADBEEF;
        @(negedge clk);
        rsp_valid = 1'b0; rsp_payload_outputs_0 = 32'h0BAD_F00D;
        for (int i = 0; i < 4; i++) begin
            vectors++; if (res_valid !== 1'b1 || res_data !== 32'hDEADBEEF || res_timeout !== 1'b0 || req_ready !== 1'b0) begin
                miscompares++; $display("FAIL rsp_hold[%0d] got v%b d%h to%b rr%b want v1 dDEADBEEF to0 rr0", i, res_valid, res_data, res_timeout, req_ready); end
            if (i == 3) res_ready = 1'b1;
            @(negedge clk);
        end
        res_ready = 1'b0;
        vectors++; if (res_valid !== 1'b0 || req_ready !== 1'b1 || stray_count !== '0) begin
            miscompares++; $display("FAIL rsp_release got v%b rr%b stray %0d want 0 1 0", res_valid, req_ready, stray_count); end
    endtask

    task automatic test_timeout();
        logic [DATA_W-1:0] v;
        req_valid = 1'b1; req_op = 3'($urandom); req_subop = 7'($urandom);
        req_in0 = $urandom; req_in1 = $urandom; cmd_ready = 1'b1;
        rsp_payload_outputs_0 = 32'h1234_5678;
        @(negedge clk);
        req_valid = 1'b0;
        vectors++; if (cmd_valid !== 1'b1) begin miscompares++; $display("FAIL to_cmd_valid got %b want 1", cmd_valid); end
        @(negedge clk);
        cmd_ready = 1'b0;
        for (int i = 0; i < TO; i++) begin
            vectors++; if (res_valid !== 1'b0) begin miscompares++; $display("FAIL to_wait[%0d] res_valid got %b want 0", i, res_valid); end
            @(negedge clk);
        end
        vectors++; if (res_valid !== 1'b1 || res_timeout !== 1'b1 || res_data !== '0) begin
            miscompares++; $display("FAIL to_expire got v%b to%b d%h want 1 1 0", res_valid, res_timeout, res_data); end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        rsp_valid = 1'b1;
        @(negedge clk);
        rsp_valid = 1'b0;
        vectors++; if (stray_count !== 8'd1 || res_valid !== 1'b0 || req_ready !== 1'b1) begin
            miscompares++; $display("FAIL to_stray got stray %0d v%b rr%b want 1 0 1", stray_count, res_valid, req_ready); end

        v = $urandom | 32'h1;
        req_valid = 1'b1; req_op = 3'($urandom); req_subop = 7'($urandom); cmd_ready = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        cmd_ready = 1'b0;
        repeat (TO - 1) @(negedge clk);
        rsp_valid = 1'b1; rsp_payload_outputs_0 = v;
        @(negedge clk);
        rsp_valid = 1'b0;
        vectors++; if (res_valid !== 1'b1 || res_timeout !== 1'b0 || res_data !== v || stray_count !== 8'd1) begin
            miscompares++; $display("FAIL to_race got v%b to%b d%h stray %0d want 1 0 %h 1", res_valid, res_timeout, res_data, stray_count, v); end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    task automatic test_reset_mid_wait();
        logic [2:0] op;
        logic [6:0] sub;
        logic [DATA_W-1:0] a, b, v;
        req_valid = 1'b1; req_op = 3'd2; req_subop = 7'd9; cmd_ready = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        vectors++; if (cmd_valid !== 1'b1) begin miscompares++; $display("FAIL rst_send_pre got cmd_valid %b want 1", cmd_valid); end
        reset_n = 1'b0;
        #1;
        vectors++; if (cmd_valid !== 1'b0 || stray_count !== '0 || cmd_payload_function_id !== '0) begin
            miscompares++; $display("FAIL rst_send_async got v%b stray %0d fid %h want 0 0 0", cmd_valid, stray_count, cmd_payload_function_id); end
        @(negedge clk);
        reset_n = 1'b1;

        req_valid = 1'b1; req_op = 3'd5; req_subop = 7'd33; cmd_ready = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        cmd_ready = 1'b0;
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        vectors++; if (cmd_valid !== 1'b0 || res_valid !== 1'b0 || req_ready !== 1'b1) begin
            miscompares++; $display("FAIL rst_wait_async got cv%b rv%b rr%b want 0 0 1", cmd_valid, res_valid, req_ready); end
        rsp_valid = 1'b1; rsp_payload_outputs_0 = 32'hCAFE_0001;
        @(negedge clk);
        rsp_valid = 1'b0;
        reset_n = 1'b1;
        @(negedge clk);
        vectors++; if (req_ready !== 1'b1 || cmd_valid !== 1'b0 || res_valid !== 1'b0 || stray_count !== '0) begin
            miscompares++; $display("FAIL rst_release got rr%b cv%b rv%b stray %0d want 1 0 0 0", req_ready, cmd_valid, res_valid, stray_count); end

        op = 3'($urandom); sub = 7'($urandom); a = $urandom; b = $urandom; v = $urandom;
        req_valid = 1'b1; req_op = op; req_subop = sub; req_in0 = a; req_in1 = b; cmd_ready = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        vectors++; if (cmd_valid !== 1'b1 || cmd_payload_function_id !== {sub, op} || cmd_payload_inputs_0 !== a || cmd_payload_inputs_1 !== b) begin
            miscompares++; $display("FAIL rst_next_cmd got v%b fid %h in %h %h want 1 %h %h %h", cmd_valid, cmd_payload_function_id,
                                    cmd_payload_inputs_0, cmd_payload_inputs_1, {sub, op}, a, b); end
        @(negedge clk);
        cmd_ready = 1'b0; rsp_valid = 1'b1; rsp_payload_outputs_0 = v;
        @(negedge clk);
        rsp_valid = 1'b0;
        vectors++; if (res_valid !== 1'b1 || res_data !== v || res_timeout !== 1'b0) begin
            miscompares++; $display("FAIL rst_next_res got v%b d%h to%b want 1 %h 0", res_valid, res_data, res_timeout, v); end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    task automatic test_stress();
        logic [STRAY_W-1:0] stray0;
        stray0 = stray_count;
        sent = 0; served = 0; got = 0;
        stress_lim = cyc + 20000;
        req_q.delete(); res_q.delete();
        fork
            begin : requester
                req_t r;
                while (sent < N_TXN && cyc < stress_lim) begin
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                    req_op = 3'($urandom); req_subop = 7'($urandom);
                    req_in0 = $urandom; req_in1 = $urandom; req_valid = 1'b1;
                    while (!req_ready && cyc < stress_lim) @(negedge clk);
                    r.fid = {req_subop, req_op}; r.a = req_in0; r.b = req_in1;
                    req_q.push_back(r);
                    res_q.push_back(cfu_model(r.fid, r.a, r.b));
                    sent++;
                    @(negedge clk);
                    req_valid = 1'b0;
                end
            end
            begin : responder
                req_t e;
                logic [DATA_W-1:0] rv;
                while (served < N_TXN && cyc < stress_lim) begin
                    @(negedge clk);
                    cmd_ready = ($urandom_range(0, 2) != 0);
                    if (cmd_valid && cmd_ready) begin
                        vectors++;
                        if (req_q.size() == 0) begin
                            miscompares++; $display("FAIL stress_cmd_extra got fid %h with no pending request", cmd_payload_function_id);
                        end else begin
                            e = req_q.pop_front();
                            if (cmd_payload_function_id !== e.fid || cmd_payload_inputs_0 !== e.a || cmd_payload_inputs_1 !== e.b) begin
                                miscompares++; $display("FAIL stress_cmd[%0d] got %h %h %h want %h %h %h", served, cmd_payload_function_id,
                                                        cmd_payload_inputs_0, cmd_payload_inputs_1, e.fid, e.a, e.b);
                            end
                        end
                        rv = cfu_model(cmd_payload_function_id, cmd_payload_inputs_0, cmd_payload_inputs_1);
                        served++;
                        @(negedge clk);
                        cmd_ready = 1'b0;
                        repeat ($urandom_range(0, 4)) @(negedge clk);
                        rsp_valid = 1'b1; rsp_payload_outputs_0 = rv;
                        @(negedge clk);
                        rsp_valid = 1'b0;
                    end
                end
                cmd_ready = 1'b0;
            end
            begin : consumer
                logic [DATA_W-1:0] ev;
                while (got < N_TXN && cyc < stress_lim) begin
                    @(negedge clk);
                    res_ready = 1'($urandom_range(0, 1));
                    if (res_valid && res_ready) begin
                        vectors++;
                        if (res_q.size() == 0) begin
                            miscompares++; $display("FAIL stress_res_extra got %h with no expected result", res_data);
                        end else begin
                            ev = res_q.pop_front();
                            if (res_data !== ev || res_timeout !== 1'b0) begin
                                miscompares++; $display("FAIL stress_res[%0d] got %h to%b want %h to0", got, res_data, res_timeout, ev);
                            end
                        end
                        got++;
                    end
                end
                res_ready = 1'b0;
            end
        join
        res_ready = 1'b1;
        repeat (12) @(negedge clk);
        vectors++; if (sent != N_TXN || served != N_TXN || got != N_TXN) begin
            miscompares++; $display("FAIL stress_counts got sent %0d served %0d results %0d want %0d each", sent, served, got, N_TXN); end
        vectors++; if (req_q.size() != 0 || res_q.size() != 0) begin
            miscompares++; $display("FAIL stress_leftover got %0d cmds %0d results outstanding want 0 0", req_q.size(), res_q.size()); end
        vectors++; if (res_valid !== 1'b0 || cmd_valid !== 1'b0 || stray_count !== stray0) begin
            miscompares++; $display("FAIL stress_quiet got rv%b cv%b stray %0d want 0 0 %0d", res_valid, cmd_valid, stray_count, stray0); end
        res_ready = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_pack();
        test_backpressure();
        test_response();
        test_timeout();
        test_reset_mid_wait();
        test_stress();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
